// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - AHB-Lite bank of enabled, divided clock-enable tick channels
module clk_div_ctrl #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clock,
    input  logic              Rst,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] ch_tick
);

    // STATUS upper fields are fixed build parameters; only the enable mirror varies
    localparam logic [31:0] STATUS_ID = (32'(DIV_W) << 24) | (32'(NUM_CH) << 16);

    logic                r_dp_valid;
    logic                r_dp_write;
    logic [5:0]          r_dp_addr;
    logic [NUM_CH-1:0]   r_ctrl;

    logic                w_accept;
    logic                w_wr_en;
    logic                w_ctrl_wr;
    logic [NUM_CH-1:0]   w_ctrl_next;
    logic [NUM_CH-1:0]   w_div_wr;
    logic [NUM_CH-1:0]   w_tick;
    logic [DIV_W-1:0]    w_div [NUM_CH];
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_accept    = HSEL & HTRANS[1] & HREADY;
    assign w_wr_en     = r_dp_valid & r_dp_write;
    assign w_ctrl_wr   = w_wr_en && (r_dp_addr == 6'd0);
    assign w_ctrl_next = w_ctrl_wr ? HWDATA[NUM_CH-1:0] : r_ctrl;

    // Address-phase capture; the valid flag lives for exactly one data phase
    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 6'd0;
        end else begin
            r_dp_valid <= w_accept;
            if (w_accept) begin
                r_dp_write <= HWRITE;
                r_dp_addr  <= HADDR[7:2];
            end
        end
    end

    // Channel enable register, written in the data phase
    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            r_ctrl <= '0;
        end else if (w_ctrl_wr) begin
            r_ctrl <= HWDATA[NUM_CH-1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] r_div;
            logic [DIV_W-1:0] r_cnt;

            assign w_div_wr[gi] = w_wr_en && (r_dp_addr == 6'(gi + 2));
            assign w_tick[gi]   = r_ctrl[gi] && (r_cnt == r_div);
            assign w_div[gi]    = r_div;

            // Divide register plus period counter; a DIV write, a disabled or
            // newly disabled channel, or an emitted tick all restart the period
            always_ff @(posedge clock or posedge Rst) begin
                if (Rst) begin
                    r_div <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_div_wr[gi]) begin
                        r_div <= HWDATA[DIV_W-1:0];
                    end
                    if (w_div_wr[gi] || !r_ctrl[gi] || !w_ctrl_next[gi] || w_tick[gi]) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Read mux from the captured address; zero outside a read data phase
    always_comb begin
        w_rdata = 32'd0;
        if (r_dp_valid && !r_dp_write) begin
            if (r_dp_addr == 6'd0) begin
                w_rdata = 32'(r_ctrl);
            end else if (r_dp_addr == 6'd1) begin
                w_rdata = STATUS_ID | 32'(r_ctrl);
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_dp_addr == 6'(i + 2)) begin
                        w_rdata = 32'(w_div[i]);
                    end
                end
            end
        end
    end

    assign HRDATA    = w_rdata;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign ch_en     = r_ctrl;
    assign ch_tick   = w_tick;

    // Address/data bits outside the decoded fields are intentionally ignored
    assign w_unused = &{1'b0, HADDR[31:8], HADDR[1:0], HTRANS[0], HWDATA};

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - randomized model-checked bench for clk_div_ctrl
module tb_clk_div_ctrl;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;

    logic              clock = 1'b0;
    logic              Rst   = 1'b1;
    logic              HSEL  = 1'b0;
    logic [31:0]       HADDR = '0;
    logic [1:0]        HTRANS = '0;
    logic              HWRITE = 1'b0;
    logic              HREADY = 1'b1;
    logic [31:0]       HWDATA = '0;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_tick;

    clk_div_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clock(clock), .Rst(Rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .ch_en(ch_en), .ch_tick(ch_tick)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: registers plus, per channel, the cycle its period began
    logic [31:0] m_ctrl;
    logic [31:0] m_div [NUM_CH];
    longint      m_start [NUM_CH];
    longint      cyc;
    bit          m_dpv;
    bit          m_dpw;
    int          m_dpa;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return m_ctrl;
        if (a == 1) return (32'(DIV_W) << 24) | (32'(NUM_CH) << 16) | m_ctrl;
        if (a >= 2 && a < NUM_CH + 2) return m_div[a-2];
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_ticks();
        logic [31:0] t = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_ctrl[i] && ((cyc - m_start[i]) % (longint'(m_div[i]) + 1) == longint'(m_div[i])))
                t[i] = 1'b1;
        end
        return t;
    endfunction

    task automatic m_reset();
        m_ctrl = '0;
        m_dpv  = 0;
        m_dpw  = 0;
        m_dpa  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]   = '0;
            m_start[i] = 0;
        end
    endtask

    task automatic m_write(input int a, input logic [31:0] wd);
        logic [31:0] nv;
        if (a == 0) begin
            nv = wd & ((32'd1 << NUM_CH) - 1);
            for (int i = 0; i < NUM_CH; i++)
                if (nv[i] && !m_ctrl[i]) m_start[i] = cyc;
            m_ctrl = nv;
        end else if (a >= 2 && a < NUM_CH + 2) begin
            m_div[a-2]   = wd & 32'(((64'd1 << DIV_W) - 1));
            m_start[a-2] = cyc;
        end
    endtask

    // One bus cycle: check outputs mid-cycle, then advance the model on the edge
    task automatic step();
        @(negedge clock);
        check("ch_en", 32'(ch_en), m_ctrl);
        check("ch_tick", 32'(ch_tick), m_ticks());
        check("hrdata", HRDATA, (m_dpv && !m_dpw) ? m_read(m_dpa) : 32'd0);
        check("hreadyout", 32'(HREADYOUT), 32'd1);
        check("hresp", 32'(HRESP), 32'd0);
        @(posedge clock);
        cyc++;
        if (m_dpv && m_dpw) m_write(m_dpa, HWDATA);
        m_dpv = HSEL && HTRANS[1] && HREADY;
        m_dpw = HWRITE;
        m_dpa = int'(HADDR[7:2]);
        #1;
    endtask

    task automatic drive(input bit sel, input logic [1:0] tr, input bit wr, input bit rdy,
                         input logic [31:0] addr, input logic [31:0] wd);
        HSEL = sel; HTRANS = tr; HWRITE = wr; HREADY = rdy; HADDR = addr; HWDATA = wd;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 2'b00, 0, 1, 32'd0, $urandom);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        drive(1, 2'b10, 1, 1, addr, $urandom);
        drive(0, 2'b00, 0, 1, 32'd0, data);
    endtask

    task automatic read_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        drive(1, 2'b10, 0, 1, addr, $urandom);
        check(tag, HRDATA, exp);
        idle(1);
    endtask

    int          tick_cnt;
    logic [31:0] addr_tbl [7] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h3C};

    initial begin
        m_reset();
        cyc = 0;
        repeat (3) @(posedge clock);
        #1 Rst = 1'b0;

        check("reset ch_en", 32'(ch_en), 32'd0);
        check("reset ch_tick", 32'(ch_tick), 32'd0);
        check("reset hrdata", HRDATA, 32'd0);
        read_expect("reset ctrl", 32'h00, 32'h0);
        read_expect("reset div0", 32'h08, 32'h0);

        // Channel 1 divided by 4
        bus_write(32'h0C, 32'd3);
        bus_write(32'h00, 32'h2);
        check("ch1 enabled", 32'(ch_en), 32'h2);
        tick_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (ch_tick[1]) tick_cnt++;
            check("other ticks", 32'(ch_tick & 4'b1101), 32'd0);
            idle(1);
        end
        check("ch1 tick count", 32'(tick_cnt), 32'd3);

        // Channel 0 ticking every cycle, then disabled
        bus_write(32'h08, 32'd0);
        bus_write(32'h00, 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("ch0 every cycle", 32'(ch_tick[0]), 32'd1);
            idle(1);
        end
        bus_write(32'h00, 32'h0);
        check("ch0 off", 32'(ch_tick), 32'd0);
        idle(2);

        // Channel 2 DIV lowered mid-period
        bus_write(32'h10, 32'd9);
        bus_write(32'h00, 32'h4);
        idle(5);
        bus_write(32'h10, 32'd2);
        check("ch2 restart t+1", 32'(ch_tick[2]), 32'd0);
        idle(1);
        check("ch2 restart t+2", 32'(ch_tick[2]), 32'd0);
        idle(1);
        check("ch2 restart t+3", 32'(ch_tick[2]), 32'd1);
        idle(4);

        // Back-to-back write then read, masking, status, unmapped space
        drive(1, 2'b10, 1, 1, 32'h00, $urandom);
        drive(1, 2'b10, 0, 1, 32'h00, 32'hFFFF_FFFF);
        check("b2b ctrl read", HRDATA, 32'h0000_000F);
        idle(1);
        read_expect("status", 32'h04, 32'h1004_000F);
        read_expect("unmapped read", 32'h3C, 32'h0);
        bus_write(32'h3C, 32'hDEAD_BEEF);
        bus_write(32'h04, 32'h0000_0000);
        read_expect("unmapped after write", 32'h3C, 32'h0);
        read_expect("ctrl after stray writes", 32'h00, 32'hF);

        // Unqualified address phases must not write
        drive(1, 2'b00, 1, 1, 32'h14, $urandom);
        drive(0, 2'b00, 0, 1, 32'd0, 32'd77);
        drive(1, 2'b10, 1, 0, 32'h14, $urandom);
        drive(0, 2'b00, 0, 1, 32'd0, 32'd55);
        read_expect("div3 unwritten", 32'h14, 32'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = addr_tbl[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
            drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) != 0, a, d);
        end

        // Asynchronous reset in the middle of a read data phase
        bus_write(32'h08, 32'd5);
        bus_write(32'h00, 32'hF);
        drive(1, 2'b10, 0, 1, 32'h00, $urandom);
        HSEL = 0; HTRANS = 2'b00;
        #2 Rst = 1'b1;
        #1;
        check("async rst ch_en", 32'(ch_en), 32'd0);
        check("async rst ch_tick", 32'(ch_tick), 32'd0);
        check("async rst hrdata", HRDATA, 32'd0);
        m_reset();
        @(posedge clock);
        cyc++;
        #1 Rst = 1'b0;
        read_expect("post rst ctrl", 32'h00, 32'h0);
        read_expect("post rst div0", 32'h08, 32'h0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
